// File: rtl/st_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : st_frame_pkg
// Description : Shared defaults for the Avalon-ST frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package st_frame_pkg;

   localparam int ST_DATA_WIDTH = 512;
   localparam int ST_DEPTH      = 8;
   localparam int ST_PKT_BEATS  = 1;
   localparam int ST_OVF_W      = 16;

endpackage : st_frame_pkg
`default_nettype wire

// File: rtl/st_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : st_fifo_core
// Description : Power-of-two word FIFO; storage plus pointers and count.
// Revision    : 1.0 - initial release
// ============================================================================
module st_fifo_core
   import st_frame_pkg::*;
#(
   parameter int DATA_WIDTH = ST_DATA_WIDTH,
   parameter int DEPTH      = ST_DEPTH,
   parameter int PTR_W      = $clog2(DEPTH),
   parameter int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic                  i_flush,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [CNT_W-1:0]      o_count
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_push;
   logic                  w_pop;

   assign w_push = i_push & ~i_flush;
   assign w_pop  = i_pop  & ~i_flush & (r_count != '0);

   // Storage carries no reset so it maps onto plain RAM/register arrays.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule : st_fifo_core
`default_nettype wire

// File: rtl/st_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : st_frame_buffer
// Description : ADC word FIFO framed into Avalon-ST packets for mSGDMA.
//               Define ST_FRAME_BUFFER_OVF_STAT_EN to build the drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module st_frame_buffer
   import st_frame_pkg::*;
#(
   parameter int DATA_WIDTH = ST_DATA_WIDTH,
   parameter int DEPTH      = ST_DEPTH,
   parameter int PKT_BEATS  = ST_PKT_BEATS
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      data_valid,
   input  logic [DATA_WIDTH-1:0]     data,
   input  logic                      flush,
   output logic [DATA_WIDTH-1:0]     sink_data,
   output logic                      sink_valid,
   input  logic                      sink_ready,
   output logic                      sink_startofpacket,
   output logic                      sink_endofpacket,
   output logic [$clog2(DEPTH):0]    fill_level,
   output logic [ST_OVF_W-1:0]       overflow_count
);

   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int BEAT_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
   localparam logic [BEAT_W-1:0] C_BEAT_LAST = BEAT_W'(PKT_BEATS - 1);
   localparam logic [CNT_W-1:0]  C_FULL      = CNT_W'(DEPTH);

   logic [CNT_W-1:0]  w_count;
   logic              w_valid;
   logic              w_pop;
   logic              w_can_push;
   logic              w_push;
   logic [BEAT_W-1:0] r_beat;

   assign w_valid    = (w_count != '0);
   assign w_pop      = w_valid & sink_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign w_can_push = (w_count != C_FULL) | w_pop;
   assign w_push     = data_valid & w_can_push & ~flush;

   st_fifo_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (flush),
      .i_data  (data),
      .o_data  (sink_data),
      .o_count (w_count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_beat <= '0;
      end else if (flush) begin
         r_beat <= '0;
      end else if (w_pop) begin
         r_beat <= (r_beat == C_BEAT_LAST) ? '0 : r_beat + BEAT_W'(1);
      end
   end

   assign sink_valid         = w_valid;
   assign sink_startofpacket = w_valid & (r_beat == '0);
   assign sink_endofpacket   = w_valid & (r_beat == C_BEAT_LAST);
   assign fill_level         = w_count;

`ifdef ST_FRAME_BUFFER_OVF_STAT_EN
   logic                r_ovf_cnt_en_unused;
   logic [ST_OVF_W-1:0] r_ovf_cnt;
   logic                w_drop;

   // Words discarded by a flush are not overflow drops.
   assign w_drop = data_valid & ~w_can_push & ~flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ovf_cnt <= '0;
      end else if (w_drop && (r_ovf_cnt != '1)) begin
         r_ovf_cnt <= r_ovf_cnt + ST_OVF_W'(1);
      end
   end

   assign r_ovf_cnt_en_unused = 1'b0;
   assign overflow_count      = r_ovf_cnt;
`else
   assign overflow_count = '0;
`endif

endmodule : st_frame_buffer
`default_nettype wire
